// File: rtl/delay_pipe.sv
// delay_pipe: DEPTH-stage valid/data delay line with a per-cycle output tap.
// Optional occupancy counter on the occ port when DELAY_PIPE_OCC_EN is defined.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (highest priority)
//   stall      hold every stage; the input sample of that cycle is dropped
//   flush      clear all valid bits and load RESET into all data (beats stall)
//   in_valid   qualifies in_data
//   in_data    data entering stage 1
//   tap        output select: 0 = input passthrough, k = stage k,
//              values above DEPTH saturate to DEPTH
//   out_valid  valid bit of the selected stage
//   out_data   data of the selected stage
//   occ        number of valid stages (only with DELAY_PIPE_OCC_EN)
module delay_pipe #(
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET = '0,
    localparam int unsigned     TW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TW-1:0]    tap,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef DELAY_PIPE_OCC_EN
    ,
    output logic [TW-1:0]    occ
`endif
);

    logic [DEPTH:1]   vld;
    logic [WIDTH-1:0] dat [1:DEPTH];
    logic             clr;
    logic [TW-1:0]    sel;

    // reset and flush have the same effect on the stages
    assign clr = reset | flush;

    // Data moves on every unstalled edge even when the valid bit is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                dat[k] <= RESET;
            end
        end else if (!stall) begin
            vld[1] <= in_valid;
            dat[1] <= in_data;
            for (int k = 2; k <= DEPTH; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    always_comb begin
        sel = tap;
        if (tap > TW'(DEPTH)) begin
            sel = TW'(DEPTH);
        end
    end

    // sel == 0 keeps the combinational passthrough default
    always_comb begin
        out_valid = in_valid;
        out_data  = in_data;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel == TW'(k)) begin
                out_valid = vld[k];
                out_data  = dat[k];
            end
        end
    end

`ifdef DELAY_PIPE_OCC_EN
    // One sample enters and one leaves per unstalled edge, so the
    // count tracks popcount(vld) and stays within 0..DEPTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            occ <= '0;
        end else if (!stall) begin
            occ <= occ + TW'(in_valid) - TW'(vld[DEPTH]);
        end
    end
`endif

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: directed stimulus with a cycle-tagged scoreboard.
// A negedge monitor compares every expectation due in the current cycle.
module tb_delay_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [2:0] tap = 3'd4;
    logic       out_valid;
    logic [7:0] out_data;
`ifdef DELAY_PIPE_OCC_EN
    logic [2:0] occ;
`endif

    delay_pipe #(
        .WIDTH(8),
        .DEPTH(4),
        .RESET(8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .tap      (tap),
        .out_valid(out_valid),
        .out_data (out_data)
`ifdef DELAY_PIPE_OCC_EN
        ,
        .occ      (occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_occ;
        logic       v;
        logic [7:0] d;
        logic [2:0] o;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(input int c, input logic v,
                      input logic [7:0] d, input string nm);
        exp_t e;
        e.cyc = c; e.is_occ = 1'b0; e.v = v;
        e.d = d; e.o = 3'd0; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic exo(input int c, input logic [2:0] o,
                       input string nm);
`ifdef DELAY_PIPE_OCC_EN
        exp_t e;
        e.cyc = c; e.is_occ = 1'b1; e.v = 1'b0;
        e.d = 8'h00; e.o = o; e.nm = nm;
        sb.push_back(e);
`else
        if (o === 3'bxxx) $display("note: bad occ arg %s at %0d", nm, c);
`endif
    endtask

    // drive one cycle of inputs, then move to 1 time unit after the edge
    task automatic cy(input logic rs, input logic st, input logic fl,
                      input logic v, input logic [7:0] d,
                      input logic [2:0] tp);
        reset = rs; stall = st; flush = fl;
        in_valid = v; in_data = d; tap = tp;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit seen;
        seen = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                vec++; miss++;
                $display("FAIL %s: expectation for cycle %0d never checked",
                         sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                vec++;
                if (sb[i].is_occ) begin
`ifdef DELAY_PIPE_OCC_EN
                    if (occ !== sb[i].o) begin
                        miss++;
                        $display("FAIL %s cyc=%0d: occ got %0d want %0d",
                                 sb[i].nm, cyc, occ, sb[i].o);
                    end
`endif
                end else begin
                    seen = 1'b1;
                    if (out_valid !== sb[i].v || out_data !== sb[i].d) begin
                        miss++;
                        $display("FAIL %s cyc=%0d: got v=%b d=%h want v=%b d=%h",
                                 sb[i].nm, cyc, out_valid, out_data,
                                 sb[i].v, sb[i].d);
                    end
                end
                sb.delete(i);
            end
        end
        if (!seen && out_valid === 1'b1) begin
            vec++; miss++;
            $display("FAIL spurious cyc=%0d: got v=1 d=%h want v=0",
                     cyc, out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int o;
        int r;
        logic [2:0] occ_seq [12];
        logic [7:0] d;
        logic [2:0] t;
        occ_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4,
                    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};

        // one reset edge, then tap 4 idle shows the reset value
        cy(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 3'd4);
        for (int i = 0; i < 4; i++) begin
            ex(cyc, 1'b0, 8'hA5, "reset_t4");
            exo(cyc, 3'd0, "reset_occ");
            cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3'd4);
        end
        // invalid data still advances
        ex(cyc, 1'b0, 8'h3C, "inv_advance");
        cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4);

        // tap 3 latency
        a = cyc;
        ex(a + 3, 1'b1, 8'h11, "t3_first");
        ex(a + 4, 1'b1, 8'h22, "t3_second");
        ex(a + 5, 1'b1, 8'h33, "t3_third");
        ex(a + 6, 1'b0, 8'h00, "t3_after");
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd3);
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 3'd3);
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd3);
        for (int i = 0; i < 4; i++) cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3);

        // tap 2 with a two-cycle stall
        b = cyc;
        ex(b + 2, 1'b1, 8'h5A, "stall_t1_hold");
        ex(b + 3, 1'b0, 8'h00, "stall_t2_hold");
        ex(b + 4, 1'b1, 8'h5A, "stall_latency");
        ex(b + 5, 1'b0, 8'h00, "stall_drop");
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 3'd2);
        cy(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 3'd2);
        cy(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 3'd1);
        for (int i = 0; i < 3; i++) cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2);
        for (int i = 0; i < 3; i++) cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);

        // fill four, then flush together with stall and in_valid
        for (int i = 0; i < 4; i++) begin
            d = 8'(i + 1);
            cy(1'b0, 1'b0, 1'b0, 1'b1, d, 3'd4);
        end
        ex(cyc, 1'b1, 8'h01, "pre_flush");
        exo(cyc, 3'd4, "full_occ");
        cy(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 3'd4);
        exo(cyc, 3'd0, "flush_occ");
        for (int i = 0; i < 5; i++) begin
            t = (i == 4) ? 3'd7 : 3'(i + 1);
            ex(cyc, 1'b0, 8'hA5, "flush_sweep");
            cy(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, t);
        end

        // passthrough and saturated tap on a moving stream
        for (int i = 0; i < 8; i++) begin
            d = 8'hC3 + 8'(i);
            if (i % 2 == 0) begin
                t = 3'd0;
                ex(cyc, 1'b1, d, "tap0_pass");
            end else begin
                t = 3'd7;
                if (i < 4) ex(cyc, 1'b0, 8'hA5, "tap7_empty");
                else       ex(cyc, 1'b1, 8'hC3 + 8'(i - 4), "tap7_sat");
            end
            cy(1'b0, 1'b0, 1'b0, 1'b1, d, t);
        end
        ex(cyc, 1'b1, 8'hC7, "tap4_equal");
        cy(1'b0, 1'b0, 1'b1, 1'b1, 8'hCB, 3'd4);

        // occupancy profile, watched at tap 1
        o = cyc;
        ex(o, 1'b0, 8'hA5, "post_flush_t1");
        exo(o, 3'd0, "occ_start");
        for (int i = 0; i < 12; i++) begin
            d = 8'h10 + 8'(i);
            ex(o + 1 + i, i < 6, d, "t1_stream");
            exo(o + 1 + i, occ_seq[i], "occ_profile");
            cy(1'b0, 1'b0, 1'b0, i < 6, d, 3'd1);
        end

        // reset mid-stream discards everything in flight
        r = cyc;
        ex(r + 2, 1'b1, 8'h91, "pre_reset");
        exo(r + 2, 3'd2, "pre_reset_occ");
        exo(r + 3, 3'd0, "post_reset_occ");
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h91, 3'd1);
        cy(1'b0, 1'b0, 1'b0, 1'b1, 8'h92, 3'd2);
        cy(1'b1, 1'b0, 1'b0, 1'b1, 8'h93, 3'd2);
        for (int i = 0; i < 4; i++) begin
            ex(cyc, 1'b0, 8'hA5, "post_reset");
            cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'(i + 1));
        end
        cy(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            vec++; miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, >= 1.
REQ-002 Parameter DEPTH, default 4: number of register stages, >= 1.
REQ-003 Parameter RESET, default all-zero WIDTH bits: per-bit data value loaded on reset/flush.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port stall  input  1: hold all stages when high.
REQ-007 Port flush  input  1: invalidate all stages when high.
REQ-008 Port in_valid  input  1: qualifies in_data.
REQ-009 Port in_data  input  WIDTH: data entering stage 1.
REQ-010 Port tap  input  TW = clog2(DEPTH+1): selects output stage, 0..DEPTH.
REQ-011 Port out_valid  output  1: valid bit of selected stage.
REQ-012 Port out_data  output  WIDTH: data of selected stage.
REQ-013 Port occ  output  TW: count of valid stages (present only per REQ-030).

Function
REQ-014 Block SHALL hold DEPTH stages, each a valid bit plus WIDTH data bits; stage k (1..DEPTH) holds the sample accepted k unstalled cycles earlier.
REQ-015 Unstalled edge: stage 1 <= {in_valid, in_data}; stage k <= stage k-1 for k = 2..DEPTH; stage DEPTH contents discarded.
REQ-016 Data SHALL advance regardless of valid; invalid stages carry data but out_valid reflects the valid bit only.
REQ-017 stall=1 (flush=0, reset=0): all stages hold; in_valid/in_data ignored; sample is lost, not queued.
REQ-018 flush=1: next edge clears all valid bits and loads RESET into all data; overrides stall and in_valid.
REQ-019 tap=0: out_valid = in_valid, out_data = in_data, combinational passthrough.
REQ-020 tap=k, 1 <= k <= DEPTH: out_valid/out_data = stage k, combinational from registers.
REQ-021 tap > DEPTH: SHALL saturate to DEPTH.
REQ-022 tap MAY change every cycle; output follows tap in the same cycle, no state disturbance.
REQ-023 Latency from in_valid to out_valid = tap unstalled cycles; stalled cycles add 1 each.
REQ-024 Simultaneous stall and flush: flush wins; simultaneous reset and anything: reset wins.

Reset
REQ-025 reset=1 at an edge: all valid bits 0, all data = RESET, occ = 0.
REQ-026 After reset with tap>=1: out_valid=0, out_data=RESET.
REQ-027 Reset mid-stream SHALL discard all in-flight samples; no partial output after deassertion.
REQ-028 Reset SHALL NOT be required to be multi-cycle; one asserted edge suffices.

Configuration
REQ-029 Macro DELAY_PIPE_OCC_EN controls the occupancy counter.
REQ-030 Defined: occ port present; registered; equals popcount of stage valid bits after each edge; incremented/decremented/held per entering and leaving valid bits; cleared by reset and flush; held on stall; range 0..DEPTH, never wraps.
REQ-031 Not defined: occ port and counter logic absent; all other behaviour identical.

Verification (WIDTH=8, DEPTH=4, RESET=8'hA5)
REQ-032 Reset then tap=4, idle -> out_valid=0, out_data=8'hA5 every cycle.
REQ-033 tap=3, in_valid=1 with 8'h11,8'h22,8'h33 on consecutive cycles -> out_valid=1 with 8'h11,8'h22,8'h33 exactly 3 cycles later each.
REQ-034 tap=2, send 8'h5A, stall 2 cycles after first edge -> 8'h5A appears at out 4 cycles after entry; input during stall not seen.
REQ-035 Fill 4 valid samples, then flush with stall=1 and in_valid=1 -> next cycle all taps out_valid=0, out_data=8'hA5; occ=0 (OCC_EN).
REQ-036 tap=0 and tap=7 sweep with data 8'hC3 streaming -> tap=0 passthrough same cycle; tap=7 identical to tap=4.
REQ-037 OCC_EN: 6 consecutive valid inputs then 6 invalid -> occ 1,2,3,4,4,4,3,2,1,0,0,0.
